// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding one shared immediate-extension unit.
// The result sits in a single-entry output register with valid/ready handshake.
module imm_ext_arbiter #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [1:0]  req0_mode,
  input  logic [15:0] req0_imm,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_mode,
  input  logic [15:0] req1_imm,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_id,
  input  logic        out_ready,
  output logic [15:0] ext_count
);

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } outState_t;

  outState_t           state;
  logic                lastGrant;
  logic                grantId;
  logic                canAccept;
  logic                accept;
  logic [1:0]          selMode;
  logic [IMM_W-1:0]    selImm;
  logic [DATA_W-1:0]   extData;
  logic [DATA_W-1:0]   outData;
  logic                outId;
  logic [CNT_W-1:0]    extCount;

  assign out_valid = (state == FULL);
  assign out_data  = outData;
  assign out_id    = outId;
  assign ext_count = extCount;

  assign canAccept = !out_valid || out_ready;

  // Lone requester wins; under contention the one not granted last wins.
  always_comb begin
    grantId = !lastGrant;
    if (req0_valid && !req1_valid) begin
      grantId = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grantId = 1'b1;
    end
  end

  assign accept     = rst_n && canAccept && (req0_valid || req1_valid);
  assign req0_ready = accept && !grantId;
  assign req1_ready = accept && grantId;

  assign selMode = grantId ? req1_mode : req0_mode;
  assign selImm  = grantId ? req1_imm  : req0_imm;

  // Shared extension datapath.
  always_comb begin
    extData = '0;
    case (selMode)
      2'b00:   extData = {{16{selImm[15]}}, selImm};
      2'b01:   extData = {16'h0000, selImm};
      2'b10:   extData = {selImm, 16'h0000};
      default: extData = {{14{selImm[15]}}, selImm, 2'b00};
    endcase
  end

  // Output register FSM, grant pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      outData   <= '0;
      outId     <= 1'b0;
      extCount  <= '0;
      lastGrant <= !FIRST_GRANT;
    end else begin
      if (out_valid && out_ready) begin
        extCount <= extCount + CNT_W'(1);
      end
      if (accept) begin
        state     <= FULL;
        outData   <= extData;
        outId     <= grantId;
        lastGrant <= grantId;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter: FIRST_GRANT, default 0, the requester favoured on the first contended cycle after reset (0 or 1).
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset: synchronous and active-low.
REQ-004 Port req0_valid, input, 1, requester 0 offers an immediate.
REQ-005 Port req0_mode, input, 2, requester 0 extension mode.
REQ-006 Port req0_imm, input, 16, requester 0 raw immediate.
REQ-007 Port req0_ready, output, 1, requester 0 transfer accepted this cycle.
REQ-008 Ports req1_valid, req1_mode, req1_imm and req1_ready SHALL match REQ-004 to REQ-007 in direction, width and meaning, for requester 1.
REQ-009 Port out_valid, output, 1, out_data holds a result.
REQ-010 Port out_data, output, 32, extended result.
REQ-011 Port out_id, output, 1, index of the requester that produced out_data.
REQ-012 Port out_ready, input, 1, the consumer takes the result this cycle.
REQ-013 Port ext_count, output, 16, number of completed output transfers; wraps modulo 2^16.

Function
REQ-014 Modes:
- 00 sign: {16{imm[15]}, imm}.
- 01 zero: {16'h0, imm}.
- 10 lui: {imm, 16'h0}.
- 11 branch: {{14{imm[15]}}, imm, 2'b00}.
REQ-015 A single shared extension datapath SHALL serve both requesters; at most one request SHALL be accepted per cycle.
REQ-016 Accept condition: can_accept = !out_valid || out_ready.
REQ-017 Grant rules, evaluated each cycle:
- Only one requester valid: it is granted.
- Both valid: the requester not granted last is granted (round-robin).
- Neither valid: no grant.
REQ-018 reqN_ready SHALL be 1 only when requester N is granted and can_accept is 1; it SHALL be combinational, and it SHALL NOT depend on the other requester's ready.
REQ-019 The last-grant pointer SHALL update only on an accepted transfer (valid && ready).
REQ-020 Latency: a request accepted in cycle N SHALL appear on out_valid, out_data and out_id in cycle N+1 (registered output).
REQ-021 Output register state machine:
- States EMPTY and FULL; out_valid is 1 exactly in FULL.
- EMPTY to FULL on accept.
- FULL to EMPTY on out_ready with no accept.
- FULL stays FULL, with new contents loaded, on out_ready plus accept in the same cycle (back-to-back throughput of 1 per cycle).
- FULL stays FULL, with outputs held stable, while out_ready is 0.
REQ-022 While out_valid is 1 and out_ready is 0, out_data and out_id SHALL NOT change, and both reqN_ready SHALL be 0.
REQ-023 A requester SHALL NOT be starved: under continuous contention, grants SHALL strictly alternate 0,1,0,1 or 1,0,1,0.
REQ-024 ext_count SHALL increment by 1 on every cycle with out_valid && out_ready; it SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 reqN_mode and reqN_imm are sampled only on the accept cycle; changes while the requester is not ready SHALL have no effect.
REQ-026 out_ready asserted while out_valid is 0 SHALL have no effect and SHALL NOT increment ext_count.

Reset
REQ-027 When rst_n is 0 at a rising clk edge, the following SHALL be set:
- out_valid = 0, out_data = 32'h0, out_id = 0, ext_count = 16'h0.
- State = EMPTY.
- Last-grant pointer set so that requester FIRST_GRANT wins the first contention.
REQ-028 While rst_n is 0, req0_ready and req1_ready SHALL be 0.
REQ-029 Reset mid-operation SHALL discard any held result without counting it; no transfer SHALL be accepted in the reset cycle.
REQ-030 The first accept SHALL be possible in the first cycle with rst_n = 1.

Verification
REQ-031 Sign/zero: req0 mode 00 imm 16'd5323 -> next cycle out_data 32'h000014CB, out_id 0; req0 mode 00 imm 16'hFEBD (-323) -> 32'hFFFFFEBD; mode 01 imm 16'hFEBD -> 32'h0000FEBD.
REQ-032 Lui/branch: req1 mode 10 imm 16'h1234 -> 32'h12340000, out_id 1; mode 11 imm 16'hFFFF -> 32'hFFFFFFFC; mode 11 imm 16'h0004 -> 32'h00000010.
REQ-033 Contention, FIRST_GRANT=0: both valid for 4 cycles with out_ready=1 -> out_id sequence 0,1,0,1; ext_count = 4.
REQ-034 Backpressure: one result held with out_ready=0 for 3 cycles while both requests are valid -> both readys 0, out_data stable; out_ready=1 -> the held result is consumed and the next result appears the following cycle.
REQ-035 Reset mid-operation: out_valid=1 with ext_count=7, then rst_n=0 for one cycle -> out_valid 0, ext_count 0, out_data 0; a request the next cycle is accepted normally.
REQ-036 Wrap: preload 65535 transfers (or force the counter) then one more transfer -> ext_count 16'h0000.
